// File: rtl/adder_tree_sched_if.sv
// Bundle of request, tree and result signals for the shared adder-tree scheduler.
// slave = scheduler side, master = clients/tree/result consumer side.
interface adder_tree_sched_if #(
    parameter int ADDER_WIDTH = 16,
    parameter int NUM_REQ     = 4,
    parameter int ACC_WIDTH   = 32
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_last;
    logic [NUM_REQ*8*ADDER_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]               req_ready;
    logic [8*ADDER_WIDTH-1:0]         tree_in;
    logic                             tree_in_valid;
    logic [ADDER_WIDTH+2:0]           tree_sum;
    logic                             res_valid;
    logic                             res_ready;
    logic [ACC_WIDTH-1:0]             res_data;
    logic [IDW-1:0]                   res_id;

    modport slave (
        input  req_valid, req_last, req_data, tree_sum, res_ready,
        output req_ready, tree_in, tree_in_valid, res_valid, res_data, res_id
    );

    modport master (
        output req_valid, req_last, req_data, tree_sum, res_ready,
        input  req_ready, tree_in, tree_in_valid, res_valid, res_data, res_id
    );
endinterface

// File: rtl/adder_tree_sched.sv
// Round-robin scheduler sharing one pipelined 8-operand adder tree; one total per packet.
// Define ADDER_SCHED_SAT_EN to saturate the accumulator instead of wrapping.
module adder_tree_sched #(
    parameter int ADDER_WIDTH = 16,
    parameter int NUM_REQ     = 4,
    parameter int ACC_WIDTH   = 32,
    parameter int TREE_LAT    = 2
) (
    input logic                clk,
    input logic                rst_n,
    adder_tree_sched_if.slave  bus
);
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BEAT_W = 8 * ADDER_WIDTH;

    typedef enum logic [2:0] {IDLE, ARB, STREAM, DRAIN, OUTPUT} state_e;

    state_e               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       gnt_q, gnt_d;
    logic [IDW-1:0]       arb_id;
    logic                 arb_found;
    logic [ACC_WIDTH-1:0] acc_q, acc_d, acc_add;
    logic [BEAT_W-1:0]    tree_in_q;
    logic [TREE_LAT:0]    vld_pipe_q, last_pipe_q;
    logic                 beat_xfer, beat_last, sum_vld, sum_last;

    assign beat_xfer = (state_q == STREAM) && bus.req_valid[gnt_q];
    assign beat_last = beat_xfer && bus.req_last[gnt_q];
    assign sum_vld   = vld_pipe_q[TREE_LAT];
    assign sum_last  = last_pipe_q[TREE_LAT];

`ifdef ADDER_SCHED_SAT_EN
    logic [ACC_WIDTH:0] acc_wide;
    assign acc_wide = {1'b0, acc_q} + (ACC_WIDTH+1)'(bus.tree_sum);
    // Once at all-ones any further add carries out, so the clamp is sticky.
    assign acc_add  = acc_wide[ACC_WIDTH] ? '1 : acc_wide[ACC_WIDTH-1:0];
`else
    assign acc_add  = acc_q + ACC_WIDTH'(bus.tree_sum);
`endif

    // First valid requester at or above the pointer, wrapping.
    always_comb begin
        logic [IDW-1:0] idx;
        arb_found = 1'b0;
        arb_id    = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDW'((int'(ptr_q) + k) % NUM_REQ);
            if (!arb_found && bus.req_valid[idx]) begin
                arb_found = 1'b1;
                arb_id    = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                acc_d = '0;
                if (|bus.req_valid) state_d = ARB;
            end
            ARB: begin
                acc_d = '0;
                if (arb_found) begin
                    gnt_d   = arb_id;
                    state_d = STREAM;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (sum_vld) acc_d = acc_add;
                if (beat_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (sum_vld) begin
                    acc_d = acc_add;
                    if (sum_last) state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                if (bus.res_ready) begin
                    ptr_d   = (gnt_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
                    state_d = (|bus.req_valid) ? ARB : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            acc_q   <= acc_d;
        end
    end

    // Stage 0 is the tree_in register; stage TREE_LAT lines up with tree_sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            tree_in_q   <= '0;
        end else begin
            vld_pipe_q  <= {vld_pipe_q[TREE_LAT-1:0], beat_xfer};
            last_pipe_q <= {last_pipe_q[TREE_LAT-1:0], beat_last};
            if (beat_xfer) tree_in_q <= bus.req_data[int'(gnt_q)*BEAT_W +: BEAT_W];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            bus.req_ready[i] = (state_q == STREAM) && (gnt_q == IDW'(i));
    end

    assign bus.tree_in       = tree_in_q;
    assign bus.tree_in_valid = vld_pipe_q[0];
    assign bus.res_valid     = (state_q == OUTPUT);
    assign bus.res_data      = acc_q;
    assign bus.res_id        = gnt_q;
endmodule
